// File: rtl/afe_pkg.sv
// Shared definitions for the AFE transmit pattern generator.
// Contents: FSM state enum, payload pattern encodings, LFSR seed/taps and
// a single-step LFSR helper.
package afe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } afe_state_e;

  typedef enum logic [1:0] {
    PAT_FRAME_CNT  = 2'b00,
    PAT_LFSR       = 2'b01,
    PAT_CONST      = 2'b10,
    PAT_FRAME_CHID = 2'b11
  } afe_pat_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 on a right-shifting register: stage 16 is bit 0,
  // so the taps land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/afe_tx_lfsr.sv
// 16-bit Fibonacci LFSR used as the pseudo-random payload source.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (loads seed)
//   i_advance     : step the register by one position
//   i_reseed      : reload the seed (has priority over i_advance)
//   o_lfsr        : current register value
module afe_tx_lfsr
  import afe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_advance,
  input  logic        i_reseed,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_reseed) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/afe_tx_gen.sv
// AFE transmit generator: emulates a multi-channel AFE word stream.
// Each frame emits one word per enabled channel (ascending), frames start
// every max(period, popcount(mask)) cycles; payload pattern, flag stamping,
// frame counting and run completion are configurable.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   test_mode_i          : scan mode, no functional effect
//   cfg_*                : run configuration (enable, clear, mask, period,
//                          frame count, continuous, pattern, const, flags)
//   busy_o               : FSM not idle
//   smpls_left_o         : frames remaining in the current run
//   done_event_o         : one-cycle run-complete pulse
//   afe_valid_o/afe_data_o : word strobe and formatted AFE word
module afe_tx_gen
  import afe_pkg::*;
#(
  parameter int AFE_DATA_WIDTH = 32,
  parameter int AFE_NUM_CHS    = 8,
  parameter int AFE_PL_WIDTH   = 16,
  parameter int AFE_CHID_LSB   = 28,
  parameter int AFE_CHID_WIDTH = 4,
  parameter int AFE_FLAG_LSB   = 16,
  parameter int AFE_FLAG_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      test_mode_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic [AFE_NUM_CHS-1:0]    cfg_ch_mask_i,
  input  logic [15:0]               cfg_period_i,
  input  logic [15:0]               cfg_num_smpls_i,
  input  logic                      cfg_continuous_i,
  input  logic [1:0]                cfg_pattern_i,
  input  logic [AFE_PL_WIDTH-1:0]   cfg_const_i,
  input  logic [7:0]                cfg_flag_interval_i,
  input  logic [AFE_FLAG_WIDTH-1:0] cfg_flag_val_i,
  output logic                      busy_o,
  output logic [15:0]               smpls_left_o,
  output logic                      done_event_o,
  output logic                      afe_valid_o,
  output logic [AFE_DATA_WIDTH-1:0] afe_data_o
);

  localparam int CH_W  = (AFE_NUM_CHS > 1) ? $clog2(AFE_NUM_CHS) : 1;
  localparam int CNT_W = CH_W + 1;

  // Lowest set mask bit at index >= from; MSB of the result flags "found".
  function automatic logic [CH_W:0] f_find(input logic [AFE_NUM_CHS-1:0] mask,
                                           input logic [CH_W:0] from);
    logic [CH_W:0] res;
    int unsigned   j;
    res = '0;
    for (int unsigned i = 0; i < AFE_NUM_CHS; i++) begin
      j = AFE_NUM_CHS - 1 - i;
      if (mask[j] && (j >= 32'(from))) res = {1'b1, CH_W'(j)};
    end
    return res;
  endfunction

  afe_state_e                r_state, w_nxt_state;
  logic [AFE_NUM_CHS-1:0]    r_mask;
  logic [CH_W-1:0]           r_ch;
  logic [15:0]               r_cnt;
  logic [15:0]               r_left;
  logic [AFE_PL_WIDTH-1:0]   r_frame;
  logic [7:0]                r_flag_cnt;
  logic                      r_valid, r_done, r_busy;
  logic [AFE_DATA_WIDTH-1:0] r_data;

  logic [CH_W:0]             w_first, w_next;
  logic [CNT_W-1:0]          w_pop;
  logic [16:0]               w_per, w_eff;
  logic                      w_start_due;
  logic                      w_emit, w_frame_start, w_run_start, w_frame_end, w_done;
  logic [CH_W-1:0]           w_ch_sel;
  logic [AFE_PL_WIDTH-1:0]   w_frame_nxt, w_payload;
  logic [7:0]                w_flag_upd, w_flag_nxt;
  logic                      w_flag_hit;
  logic [AFE_CHID_WIDTH-1:0] w_chid;
  logic [AFE_DATA_WIDTH-1:0] w_word;
  logic [15:0]               w_lfsr;
  logic                      w_unused;

  assign w_unused = test_mode_i;

  assign w_first = f_find(cfg_ch_mask_i, '0);
  assign w_next  = f_find(r_mask, {1'b0, r_ch} + CNT_W'(1));

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < AFE_NUM_CHS; i++) begin
      w_pop = w_pop + CNT_W'(r_mask[i]);
    end
  end

  assign w_per       = (cfg_period_i == '0) ? 17'd1 : {1'b0, cfg_period_i};
  assign w_eff       = (w_per > 17'(w_pop)) ? w_per : 17'(w_pop);
  assign w_start_due = ({1'b0, r_cnt} + 17'd1) >= w_eff;

  afe_tx_lfsr u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_advance (w_emit & ~cfg_clr_i),
    .i_reseed  (cfg_clr_i),
    .o_lfsr    (w_lfsr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_state <= IDLE;
    else if (cfg_clr_i) r_state <= IDLE;
    else                r_state <= w_nxt_state;
  end

  // Decisions are made one cycle ahead: the word chosen here appears on
  // the registered outputs in the following cycle.
  always_comb begin
    w_nxt_state   = r_state;
    w_emit        = 1'b0;
    w_ch_sel      = r_ch;
    w_frame_start = 1'b0;
    w_run_start   = 1'b0;
    w_frame_end   = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cfg_en_i && w_first[CH_W] && (cfg_continuous_i || cfg_num_smpls_i != '0)) begin
          w_nxt_state   = EMIT;
          w_emit        = 1'b1;
          w_ch_sel      = w_first[CH_W-1:0];
          w_frame_start = 1'b1;
          w_run_start   = 1'b1;
        end
      end
      EMIT: begin
        if (w_next[CH_W]) begin
          w_emit   = 1'b1;
          w_ch_sel = w_next[CH_W-1:0];
        end else begin
          w_frame_end = 1'b1;
          if (!cfg_continuous_i && r_left <= 16'd1) begin
            w_nxt_state = IDLE;
            w_done      = 1'b1;
          end else if (!cfg_en_i) begin
            w_nxt_state = IDLE;
          end else if (w_start_due) begin
            if (w_first[CH_W]) begin
              w_emit        = 1'b1;
              w_ch_sel      = w_first[CH_W-1:0];
              w_frame_start = 1'b1;
            end else begin
              w_nxt_state = IDLE;
            end
          end else begin
            w_nxt_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!cfg_en_i) begin
          w_nxt_state = IDLE;
        end else if (w_start_due) begin
          if (w_first[CH_W]) begin
            w_nxt_state   = EMIT;
            w_emit        = 1'b1;
            w_ch_sel      = w_first[CH_W-1:0];
            w_frame_start = 1'b1;
          end else begin
            w_nxt_state = IDLE;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // A back-to-back frame's first word is formed in the same cycle the old
  // frame ends, so it must see the already-advanced frame/flag counters.
  always_comb begin
    w_flag_upd  = (cfg_flag_interval_i == '0 || r_flag_cnt >= cfg_flag_interval_i - 8'd1)
                  ? '0 : r_flag_cnt + 8'd1;
    w_frame_nxt = w_frame_end ? r_frame + AFE_PL_WIDTH'(1) : r_frame;
    w_flag_nxt  = w_frame_end ? w_flag_upd : r_flag_cnt;
    w_flag_hit  = (cfg_flag_interval_i != '0) && (w_flag_nxt == cfg_flag_interval_i - 8'd1);
    w_chid      = AFE_CHID_WIDTH'(w_ch_sel);
    unique case (afe_pat_e'(cfg_pattern_i))
      PAT_FRAME_CNT:  w_payload = w_frame_nxt;
      PAT_LFSR:       w_payload = AFE_PL_WIDTH'(w_lfsr);
      PAT_CONST:      w_payload = cfg_const_i;
      PAT_FRAME_CHID: w_payload = {w_frame_nxt[AFE_PL_WIDTH-1:AFE_CHID_WIDTH], w_chid};
      default:        w_payload = w_frame_nxt;
    endcase
    w_word = '0;
    w_word[AFE_PL_WIDTH-1:0] = w_payload;
    w_word[AFE_FLAG_LSB +: AFE_FLAG_WIDTH] = w_flag_hit ? cfg_flag_val_i : '0;
    w_word[AFE_CHID_LSB +: AFE_CHID_WIDTH] = w_chid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_left     <= '0;
      r_frame    <= '0;
      r_flag_cnt <= '0;
      r_cnt      <= '0;
      r_mask     <= '0;
      r_ch       <= '0;
    end else if (cfg_clr_i) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_left     <= '0;
      r_frame    <= '0;
      r_flag_cnt <= '0;
      r_cnt      <= '0;
      r_mask     <= '0;
      r_ch       <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_data <= w_word;
        r_ch   <= w_ch_sel;
      end
      r_done <= w_done;
      r_busy <= (w_nxt_state != IDLE);
      if (w_frame_start) begin
        r_mask <= cfg_ch_mask_i;
        r_cnt  <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_run_start) begin
        r_left <= cfg_num_smpls_i;
      end else if (w_frame_end && !cfg_continuous_i && r_left != '0) begin
        r_left <= r_left - 16'd1;
      end
      if (w_frame_end) begin
        r_frame    <= w_frame_nxt;
        r_flag_cnt <= w_flag_upd;
      end
    end
  end

  assign busy_o       = r_busy;
  assign smpls_left_o = r_left;
  assign done_event_o = r_done;
  assign afe_valid_o  = r_valid;
  assign afe_data_o   = r_data;

endmodule

// File: doc/afe_tx_gen.md
AFE_TX_GEN -- requirements
Module: afe_tx_gen

Interface
REQ-001 SHALL have parameter AFE_DATA_WIDTH, default 32, AFE word width.
REQ-002 SHALL have parameter AFE_NUM_CHS, default 8, number of emulated channels.
REQ-003 SHALL have parameter AFE_PL_WIDTH, default 16, payload width at bit 0.
REQ-004 SHALL have parameter AFE_CHID_LSB, default 28, channel-ID field LSB.
REQ-005 SHALL have parameter AFE_CHID_WIDTH, default 4, channel-ID field width.
REQ-006 SHALL have parameter AFE_FLAG_LSB, default 16, flag field LSB.
REQ-007 SHALL have parameter AFE_FLAG_WIDTH, default 4, flag field width.
REQ-008 SHALL have port clk_i, input, 1, the only clock.
REQ-009 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port test_mode_i, input, 1, scan mode with no functional effect.
REQ-011 SHALL have port cfg_en_i, input, 1, generation enable (level).
REQ-012 SHALL have port cfg_clr_i, input, 1, synchronous abort/clear (pulse).
REQ-013 SHALL have port cfg_ch_mask_i, input, AFE_NUM_CHS, enabled channels.
REQ-014 SHALL have port cfg_period_i, input, 16, cycles between frame starts.
REQ-015 SHALL have port cfg_num_smpls_i, input, 16, frames per run.
REQ-016 SHALL have ports cfg_continuous_i (input, 1, ignore frame count), cfg_pattern_i (input, 2, payload pattern) and cfg_const_i (input, AFE_PL_WIDTH, constant payload).
REQ-017 SHALL have ports cfg_flag_interval_i (input, 8, flag period in frames; 0 = off) and cfg_flag_val_i (input, AFE_FLAG_WIDTH, flag value).
REQ-018 SHALL have ports busy_o (output, 1, not IDLE), smpls_left_o (output, 16, frames remaining) and done_event_o (output, 1, run-complete pulse).
REQ-019 SHALL have ports afe_valid_o (output, 1, word strobe; no backpressure) and afe_data_o (output, AFE_DATA_WIDTH, AFE word).

Function
REQ-020 SHALL use FSM states IDLE, EMIT and WAIT; all outputs registered.
REQ-021 SHALL, in IDLE with cfg_en_i=1, mask!=0 and (continuous or num_smpls!=0), latch mask and num_smpls and enter EMIT; first afe_valid_o is in the next cycle.
REQ-022 SHALL, in EMIT, output one word per cycle for each latched enabled channel, in ascending order; a frame is all such words, and mask changes take effect only at frame start.
REQ-023 SHALL format each word with payload at [AFE_PL_WIDTH-1:0], flags at AFE_FLAG_LSB and chid at AFE_CHID_LSB; all other bits SHALL be 0.
REQ-024 SHALL select the payload pattern as follows: 00 frame counter (wraps at 2^AFE_PL_WIDTH); 01 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1, advanced per word); 10 cfg_const_i; 11 frame counter with its low AFE_CHID_WIDTH bits replaced by chid.
REQ-025 SHALL set the flag field to cfg_flag_val_i on every cfg_flag_interval_i-th frame (frame index mod interval = interval-1), else 0.
REQ-026 SHALL start the next frame max(cfg_period_i, popcount(mask)) cycles after the previous frame start, with period 0 treated as 1; if the period is less than or equal to popcount(mask), frames SHALL run back-to-back without a WAIT gap.
REQ-027 SHALL, when not continuous, decrement smpls_left_o at each frame end; when it reaches 0 it SHALL return to IDLE and pulse done_event_o for one cycle in the cycle after the last word.
REQ-028 SHALL, when cfg_en_i drops, complete the current frame, then go IDLE without asserting done_event_o; a drop during WAIT SHALL go IDLE immediately.
REQ-029 SHALL, on cfg_clr_i (which has priority over cfg_en_i), go IDLE with afe_valid_o low in the next cycle and zero the frame counter, flag counter and smpls_left_o, and reseed the LFSR.

Reset
REQ-030 SHALL, under reset, hold state IDLE, afe_valid_o=0, afe_data_o=0, busy_o=0, done_event_o=0 and smpls_left_o=0, with LFSR=16'hACE1 and all counters 0.
REQ-031 SHALL, when reset asserts mid-frame, drop afe_valid_o immediately and emit no residual word after release.

Structure
REQ-032 SHALL take the state enum, pattern encodings, LFSR seed and taps from shared package afe_pkg.
REQ-033 SHALL place the LFSR in sub-module afe_tx_lfsr (inputs: advance, reseed).

Verification
REQ-034 SHALL verify: mask=8'h05, period=10, num=3, pattern 00 -> words chid0/chid2 at cycles 1-2, 11-12 and 21-22 with payloads 0, 1, 2, then done_event_o at cycle 23.
REQ-035 SHALL verify: mask=8'hFF, period=2, continuous -> afe_valid_o continuously high, chid sequence 0..7 repeating.
REQ-036 SHALL verify: pattern 01, mask=8'h01 -> payloads 16'hACE1, 16'h5670, 16'hAB38.
REQ-037 SHALL verify: flag_interval=4, flag_val=4'h9 -> bits [19:16]=9 only in frames 3 and 7.
REQ-038 SHALL verify: cfg_en_i dropped at the 3rd word of an 8-word frame -> 5 more words, then IDLE, no done_event_o.
REQ-039 SHALL verify: cfg_clr_i mid-frame -> afe_valid_o low in the next cycle, smpls_left_o=0, and the first word after restart has LFSR payload 16'hACE1.
